// File: rtl/basys3_input_conditioner_pkg.sv
// Shared constants for the Basys3 input conditioner: button indices, defaults, and the reset FSM state type.
package basys3_pkg;
   localparam int CLK_HZ              = 100_000_000;
   localparam int BTN_C               = 0;
   localparam int BTN_U               = 1;
   localparam int BTN_L               = 2;
   localparam int BTN_R               = 3;
   localparam int BTN_D               = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int RST_HOLD_CYCLES_DEF = 16;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } rst_state_e;
endpackage

// File: rtl/basys3_input_conditioner_debounce_ch.sv
// One input channel: two-flop synchroniser followed by a stable-level debouncer.
module debounce_ch
   import basys3_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o
);
   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d   = {sync_q[0], raw_i};
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync_q[1] == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = sync_q[1];
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   // Look-ahead edge so the registered press pulse lines up with the level change.
   assign rise_o   = stable_d & ~stable_q;
endmodule

// File: rtl/basys3_input_conditioner.sv
// Basys3 input stage: debounced switches/buttons, press pulses, and a stretched design reset.
module basys3_input_conditioner
   import basys3_pkg::*;
#(
   parameter int NUM_SW          = 16,
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SW-1:0]  sw_i,
   input  logic [NUM_BTN-1:0] btn_i,
   output logic [NUM_SW-1:0]  sw_o,
   output logic [NUM_BTN-1:0] btn_level_o,
   output logic [NUM_BTN-1:0] btn_press_o,
   output logic               dut_rst_no,
   output logic               ena_o
);
   localparam int            HW       = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES - 1);

   logic [NUM_SW-1:0]  sw_rise_unused;
   logic [NUM_BTN-1:0] btn_rise;
   logic [NUM_BTN-1:0] press_q, press_d;
   rst_state_e         state_q, state_d;
   logic [HW-1:0]      hold_cnt_q, hold_cnt_d;

   for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
      debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (sw_i[g]),
         .stable_o (sw_o[g]),
         .rise_o   (sw_rise_unused[g])
      );
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (btn_i[g]),
         .stable_o (btn_level_o[g]),
         .rise_o   (btn_rise[g])
      );
   end

   always_comb begin
      press_d    = btn_rise;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (btn_level_o[BTN_C]) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_MAX) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (btn_level_o[BTN_C]) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press_q    <= '0;
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
      end else begin
         press_q    <= press_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign btn_press_o = press_q;
   assign dut_rst_no  = (state_q == ST_RUN);
   assign ena_o       = dut_rst_no;
endmodule

// File: tb/tb_basys3_input_conditioner.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle; a monitor checks them.
module tb_basys3_input_conditioner;
   localparam int NSW = 16;
   localparam int NBT = 5;

   typedef struct {
      int          cyc;
      logic [27:0] val;
   } ev_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NSW-1:0] sw_i;
   logic [NBT-1:0] btn_i;
   logic [NSW-1:0] sw_o;
   logic [NBT-1:0] btn_level_o;
   logic [NBT-1:0] btn_press_o;
   logic           dut_rst_no;
   logic           ena_o;

   int  cyc = 0;
   int  total = 0;
   int  passed = 0;
   ev_t q[$];

   logic [NSW-1:0] m_sw = '0;
   logic [NBT-1:0] m_lvl = '0;
   logic [NBT-1:0] m_prs = '0;
   logic           m_rst = 1'b0;

   basys3_input_conditioner #(
      .NUM_SW(NSW), .NUM_BTN(NBT), .DEBOUNCE_CYCLES(8), .RST_HOLD_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw_i(sw_i), .btn_i(btn_i),
      .sw_o(sw_o), .btn_level_o(btn_level_o), .btn_press_o(btn_press_o),
      .dut_rst_no(dut_rst_no), .ena_o(ena_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [27:0] out_now();
      return {sw_o, btn_level_o, btn_press_o, dut_rst_no, ena_o};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int c);
      ev_t e;
      e.cyc = c;
      e.val = {m_sw, m_lvl, m_prs, m_rst, m_rst};
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   endtask

   // Monitor: every change of the output bundle must match the next queued event.
   logic [27:0] prev = '0;
   always @(negedge clk) begin
      logic [27:0] cur;
      ev_t e;
      cur = out_now();
      if (cur !== prev) begin
         if (q.size() == 0) begin
            chk("unexpected_change", {4'h0, cur}, {4'h0, prev});
         end else begin
            e = q.pop_front();
            chk("event_cycle", e.cyc, cyc);
            chk("event_value", {4'h0, cur}, {4'h0, e.val});
         end
         prev = cur;
      end
   end

   initial begin
      repeat (3000) @(posedge clk);
      total++;
      $display("FAIL watchdog: cycle budget expired with %0d events pending", q.size());
      finish_run();
   end

   initial begin
      int t, a, r;
      rst_n = 1'b0;
      sw_i  = '0;
      btn_i = '0;

      // 1: reset, then release with everything idle.
      step(3);
      chk("reset_outputs", {4'h0, out_now()}, 32'h0);
      t = cyc; rst_n = 1'b1;
      m_rst = 1'b1; push(t + 4);
      step(8);

      // 2: clean switch edge.
      t = cyc; sw_i[3] = 1'b1;
      m_sw[3] = 1'b1; push(t + 10);
      step(14);

      // 3: 7-cycle pulse is filtered; 8-cycle pulse passes.
      sw_i[5] = 1'b1; step(7); sw_i[5] = 1'b0;
      step(15);
      t = cyc; sw_i[5] = 1'b1;
      m_sw[5] = 1'b1; push(t + 10);
      step(8); sw_i[5] = 1'b0;
      m_sw[5] = 1'b0; push(t + 18);
      step(14);

      // 4: bouncing button, then a solid press and release.
      for (int k = 0; k < 10; k++) begin
         btn_i[1] = (k % 2 == 0);
         step(3);
      end
      t = cyc; btn_i[1] = 1'b1;
      m_lvl[1] = 1'b1; m_prs[1] = 1'b1; push(t + 10);
      m_prs[1] = 1'b0; push(t + 11);
      step(20);
      r = cyc; btn_i[1] = 1'b0;
      m_lvl[1] = 1'b0; push(r + 10);
      step(14);

      // 5: centre button resets the design and re-arms after the hold.
      t = cyc; btn_i[0] = 1'b1;
      m_lvl[0] = 1'b1; m_prs[0] = 1'b1; push(t + 10);
      m_prs[0] = 1'b0; m_rst = 1'b0; push(t + 11);
      step(20);
      r = cyc; btn_i[0] = 1'b0;
      m_lvl[0] = 1'b0; push(r + 10);
      m_rst = 1'b1; push(r + 14);
      step(18);

      // 6: system reset mid-debounce discards the partial count.
      t = cyc; sw_i[0] = 1'b1;
      step(7);
      a = cyc; rst_n = 1'b0;
      m_sw = '0; m_lvl = '0; m_prs = '0; m_rst = 1'b0; push(a + 1);
      step(3);
      chk("midop_reset_outputs", {4'h0, out_now()}, 32'h0);
      t = cyc; rst_n = 1'b1;
      m_rst = 1'b1; push(t + 4);
      m_sw[0] = 1'b1; m_sw[3] = 1'b1; push(t + 10);
      step(15);

      chk("pending_events", q.size(), 0);
      finish_run();
   end
endmodule
